// File: rtl/iommu_msi_if_extractor_if.sv
// iommu_msi_if_extractor_if: request/response bundle between the device-context fetch, the extractor and the MSI PTE walker
interface iommu_msi_if_extractor_if #(
   parameter int ADDR_W     = 52,
   parameter int PPN_W      = 44,
   parameter int PTE_ADDR_W = 56
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADDR_W-1:0]     gpa_ppn_i;
   logic [ADDR_W-1:0]     mask_i;
   logic [ADDR_W-1:0]     pattern_i;
   logic [PPN_W-1:0]      msiptp_ppn_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic                  rsp_is_msi_o;
   logic [ADDR_W-1:0]     rsp_if_num_o;
   logic [PTE_ADDR_W-1:0] rsp_pte_addr_o;
   modport master (
      output req_valid_i, gpa_ppn_i, mask_i, pattern_i, msiptp_ppn_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_is_msi_o, rsp_if_num_o, rsp_pte_addr_o
   );
   modport slave (
      input  req_valid_i, gpa_ppn_i, mask_i, pattern_i, msiptp_ppn_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_is_msi_o, rsp_if_num_o, rsp_pte_addr_o
   );
endinterface

// File: rtl/iommu_msi_if_extractor.sv
// iommu_msi_if_extractor: MSI window hit check, bit-serial interrupt-file extraction and MSI PTE address formation
module iommu_msi_if_extractor #(
   parameter int ADDR_W         = 52,
   parameter int BITS_PER_CYCLE = 4,
   parameter int PPN_W          = 44,
   parameter int PTE_ADDR_W     = 56
) (
   input logic                     clk_i,
   input logic                     rst_i,
   input logic                     abort_i,
   iommu_msi_if_extractor_if.slave bus
);
   localparam int N      = ADDR_W / BITS_PER_CYCLE;
   localparam int STEP_W = N > 1 ? $clog2(N) : 1;
   localparam int IDX_W  = $clog2(ADDR_W + 1);
   typedef enum logic [1:0] {IDLE, EXTRACT, DONE} state_e;
   state_e                    state_q, state_d;
   logic [ADDR_W-1:0]         gpa_q, gpa_d, mask_q, mask_d, if_num_q, if_num_d;
   logic [PPN_W-1:0]          ppn_q, ppn_d;
   logic [STEP_W-1:0]         step_q, step_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      is_msi_q, is_msi_d;
   logic [PTE_ADDR_W-1:0]     pte_q, pte_d;
   logic [BITS_PER_CYCLE-1:0] m_chunk, g_chunk;
   logic                      accept, hit, last_step;
   assign hit       = ((bus.gpa_ppn_i ^ bus.pattern_i) & ~bus.mask_i) == '0;
   assign accept    = bus.req_valid_i && state_q == IDLE && !abort_i;
   assign last_step = step_q == STEP_W'(N - 1);
   assign m_chunk   = BITS_PER_CYCLE'(mask_q >> (step_q * BITS_PER_CYCLE));
   assign g_chunk   = BITS_PER_CYCLE'(gpa_q >> (step_q * BITS_PER_CYCLE));
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         gpa_q    <= '0;
         mask_q   <= '0;
         ppn_q    <= '0;
         step_q   <= '0;
         idx_q    <= '0;
         if_num_q <= '0;
         is_msi_q <= 1'b0;
         pte_q    <= '0;
      end else begin
         state_q  <= state_d;
         gpa_q    <= gpa_d;
         mask_q   <= mask_d;
         ppn_q    <= ppn_d;
         step_q   <= step_d;
         idx_q    <= idx_d;
         if_num_q <= if_num_d;
         is_msi_q <= is_msi_d;
         pte_q    <= pte_d;
      end
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = accept ? (hit ? EXTRACT : DONE) : IDLE;
         EXTRACT: state_d = abort_i ? IDLE : (last_step ? DONE : EXTRACT);
         DONE:    state_d = (abort_i || bus.rsp_ready_i) ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // Mask bits are scanned in ascending order; each set bit packs the next gpa bit into if_num.
   always_comb begin
      gpa_d    = gpa_q;
      mask_d   = mask_q;
      ppn_d    = ppn_q;
      step_d   = step_q;
      idx_d    = idx_q;
      if_num_d = if_num_q;
      is_msi_d = is_msi_q;
      pte_d    = pte_q;
      if (accept) begin
         gpa_d    = bus.gpa_ppn_i;
         mask_d   = bus.mask_i;
         ppn_d    = bus.msiptp_ppn_i;
         is_msi_d = hit;
         step_d   = '0;
         idx_d    = '0;
         if_num_d = '0;
         pte_d    = '0;
      end else if (state_q == EXTRACT) begin
         for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (m_chunk[j]) begin
               if_num_d[idx_d] = g_chunk[j];
               idx_d = idx_d + IDX_W'(1);
            end
         end
         step_d = step_q + STEP_W'(1);
         if (last_step) pte_d = PTE_ADDR_W'({ppn_q, 12'b0}) + (PTE_ADDR_W'(if_num_d) << 4);
      end
   end
   always_comb begin
      bus.req_ready_o    = state_q == IDLE;
      bus.rsp_valid_o    = state_q == DONE;
      bus.rsp_is_msi_o   = is_msi_q;
      bus.rsp_if_num_o   = if_num_q;
      bus.rsp_pte_addr_o = pte_q;
   end
endmodule
